// File: rtl/instr_encoder_if.sv
// instr_encoder_if: field-bundle / instruction-memory bus for instr_encoder.
//   Parameter ADDR_W : instruction-memory word-address width.
//   Master side (bench/harness) drives clear, in_valid and the decoded fields.
//   It observes in_ready, the memory write port, word_count, err and full.
//   Slave side (instr_encoder) has the opposite directions.
interface instr_encoder_if #(
  parameter int ADDR_W = 6
);
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        fmt;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [31:0]       imm;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic [ADDR_W:0]   word_count;
  logic              err;
  logic              full;

  modport master (
    output clear, in_valid, fmt, opcode, funct3, funct7, rd, rs1, rs2, imm,
    input  in_ready, im_we, im_addr, im_wdata, word_count, err, full
  );

  modport slave (
    input  clear, in_valid, fmt, opcode, funct3, funct7, rd, rs1, rs2, imm,
    output in_ready, im_we, im_addr, im_wdata, word_count, err, full
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RV32I fields into 32-bit machine words and
// writes them to consecutive instruction-memory word addresses.
//   clk, rst : rising-edge clock, asynchronous active-high reset.
//   bus      : instr_encoder_if.slave (clear, valid/ready field bundle,
//              im_we/im_addr/im_wdata write port, word_count, err, full).
// Optional feature: define ENC_RANGE_CHECK_EN to reject immediates that do
// not fit their format (and misaligned B/J offsets). Without it, only the
// illegal format codes 110/111 are rejected and immediates are truncated.
module instr_encoder #(
  parameter int ADDR_W = 6
) (
  input logic            clk,
  input logic            rst,
  instr_encoder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ENC, WR, FULL} stateT;

  localparam logic [ADDR_W:0]   CAPACITY = (ADDR_W+1)'(1) << ADDR_W;
  localparam logic [ADDR_W:0]   ONE_CNT  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ONE_PTR  = ADDR_W'(1);

  stateT             r_state;
  logic [2:0]        r_fmt;
  logic [6:0]        r_opcode;
  logic [2:0]        r_funct3;
  logic [6:0]        r_funct7;
  logic [4:0]        r_rd;
  logic [4:0]        r_rs1;
  logic [4:0]        r_rs2;
  logic [31:0]       r_imm;
  logic              r_imWe;
  logic              r_err;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_count;
  logic [31:0]       r_wdata;

  logic              w_isShift;
  logic              w_legal;
  logic [31:0]       w_word;
  logic [ADDR_W:0]   w_countNext;

  // Immediate-form shifts (slli/srli/srai) carry funct7 in the top bits
  // and only a 5-bit shift amount.
  assign w_isShift = (r_fmt == 3'b000) && (r_opcode == 7'b0010011) &&
                     ((r_funct3 == 3'b001) || (r_funct3 == 3'b101));

  assign w_countNext = r_count + ONE_CNT;

  // Bit packing per format; B and J scramble the offset bits the way the
  // hardware decoder expects, and never store bit 0.
  always_comb begin
    w_word = 32'h0;
    case (r_fmt)
      3'b000: begin
        if (w_isShift) begin
          w_word = {r_funct7, r_imm[4:0], r_rs1, r_funct3, r_rd, r_opcode};
        end else begin
          w_word = {r_imm[11:0], r_rs1, r_funct3, r_rd, r_opcode};
        end
      end
      3'b001: w_word = {r_imm[11:5], r_rs2, r_rs1, r_funct3, r_imm[4:0], r_opcode};
      3'b010: w_word = {r_imm[12], r_imm[10:5], r_rs2, r_rs1, r_funct3,
                        r_imm[4:1], r_imm[11], r_opcode};
      3'b011: w_word = {r_imm[20], r_imm[10:1], r_imm[11], r_imm[19:12], r_rd, r_opcode};
      3'b100: w_word = {r_imm[31:12], r_rd, r_opcode};
      3'b101: w_word = {r_funct7, r_rs2, r_rs1, r_funct3, r_rd, r_opcode};
      default: w_word = 32'h0;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  logic signed [31:0] w_simm;
  assign w_simm = $signed(r_imm);
`endif

  // Legality: the format code is always checked; immediate ranges and
  // offset alignment only when range checking is built in.
  always_comb begin
    w_legal = 1'b1;
    case (r_fmt)
      3'b110, 3'b111: w_legal = 1'b0;
`ifdef ENC_RANGE_CHECK_EN
      3'b000: begin
        if (w_isShift) begin
          w_legal = (w_simm >= 32'sd0) && (w_simm <= 32'sd31);
        end else begin
          w_legal = (w_simm >= -32'sd2048) && (w_simm <= 32'sd2047);
        end
      end
      3'b001: w_legal = (w_simm >= -32'sd2048) && (w_simm <= 32'sd2047);
      3'b010: w_legal = (w_simm >= -32'sd4096) && (w_simm <= 32'sd4094) && !r_imm[0];
      3'b011: w_legal = (w_simm >= -32'sd1048576) && (w_simm <= 32'sd1048574) && !r_imm[0];
      3'b100: w_legal = (r_imm[11:0] == 12'h000);
`endif
      default: w_legal = 1'b1;
    endcase
  end

  // Control FSM. clear takes priority over everything, so a bundle offered
  // in the same cycle is never captured and an in-flight one never writes.
  // When the last free word is written the pointer is held rather than
  // wrapped; only clear or rst brings it back to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_fmt    <= 3'b000;
      r_opcode <= 7'h00;
      r_funct3 <= 3'b000;
      r_funct7 <= 7'h00;
      r_rd     <= 5'd0;
      r_rs1    <= 5'd0;
      r_rs2    <= 5'd0;
      r_imm    <= 32'h0;
      r_imWe   <= 1'b0;
      r_err    <= 1'b0;
      r_ptr    <= '0;
      r_count  <= '0;
      r_wdata  <= 32'h0;
    end else begin
      r_imWe <= 1'b0;
      r_err  <= 1'b0;
      if (bus.clear) begin
        r_state <= IDLE;
        r_ptr   <= '0;
        r_count <= '0;
        r_wdata <= 32'h0;
      end else begin
        case (r_state)
          IDLE: begin
            if (bus.in_valid) begin
              r_fmt    <= bus.fmt;
              r_opcode <= bus.opcode;
              r_funct3 <= bus.funct3;
              r_funct7 <= bus.funct7;
              r_rd     <= bus.rd;
              r_rs1    <= bus.rs1;
              r_rs2    <= bus.rs2;
              r_imm    <= bus.imm;
              r_state  <= ENC;
            end
          end
          ENC: begin
            if (w_legal) begin
              r_wdata <= w_word;
              r_imWe  <= 1'b1;
              r_state <= WR;
            end else begin
              r_err   <= 1'b1;
              r_state <= IDLE;
            end
          end
          WR: begin
            r_count <= w_countNext;
            if (w_countNext == CAPACITY) begin
              r_state <= FULL;
            end else begin
              r_ptr   <= r_ptr + ONE_PTR;
              r_state <= IDLE;
            end
          end
          FULL: r_state <= FULL;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.in_ready   = (r_state == IDLE);
  assign bus.full       = (r_state == FULL);
  assign bus.im_we      = r_imWe;
  assign bus.im_addr    = r_ptr;
  assign bus.im_wdata   = r_wdata;
  assign bus.word_count = r_count;
  assign bus.err        = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed scoreboard bench for instr_encoder (ADDR_W=2,
// so the memory fills after four words). Stimulus pushes expected writes or
// rejections; a negedge monitor pops and compares whenever im_we or err fires.
module tb_instr_encoder;

  localparam int AW    = 2;
  localparam int K_NONE = 0;
  localparam int K_WR   = 1;
  localparam int K_ERR  = 2;

`ifdef ENC_RANGE_CHECK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  instr_encoder_if #(.ADDR_W(AW)) bus ();

  instr_encoder #(.ADDR_W(AW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    string         name;
  } wrT;

  wrT            wrQ[$];
  wrT            monE;
  int            errPending = 0;
  int            tests      = 0;
  int            errors     = 0;
  logic [AW-1:0] modelPtr   = '0;

  // Compares one observed value against its expectation.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Waits (bounded) for in_ready, offers one bundle for a single cycle and
  // records what the encoder should do with it. Returns at the negedge
  // after acceptance, when the encoder is in its encode cycle.
  task automatic applyStimulus(input logic [2:0] fmt, input logic [6:0] opc,
                               input logic [2:0] f3, input logic [6:0] f7,
                               input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [31:0] imm,
                               input int kind, input logic [31:0] expWord,
                               input string name);
    int waitCycles;
    waitCycles = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    if (bus.in_ready !== 1'b1) begin
      tests++;
      errors++;
      $display("[TB] FAIL %s_ready_timeout: in_ready=%b, expected 1", name, bus.in_ready);
      return;
    end
    bus.fmt      = fmt;
    bus.opcode   = opc;
    bus.funct3   = f3;
    bus.funct7   = f7;
    bus.rd       = rd;
    bus.rs1      = rs1;
    bus.rs2      = rs2;
    bus.imm      = imm;
    bus.in_valid = 1'b1;
    if (kind == K_WR) begin
      wrQ.push_back('{modelPtr, expWord, name});
      modelPtr = modelPtr + 1'b1;
    end else if (kind == K_ERR) begin
      errPending++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  task automatic doClear();
    @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    modelPtr = '0;
  endtask

  task automatic checkIdleState(input string tag, input logic [31:0] expCnt,
                                input logic [31:0] expAddr);
    checkOutput({tag, "_word_count"}, 32'(bus.word_count), expCnt);
    checkOutput({tag, "_im_addr"}, 32'(bus.im_addr), expAddr);
    checkOutput({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    checkOutput({tag, "_full"}, 32'(bus.full), 32'd0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    checkOutput({tag, "_im_we"}, 32'(bus.im_we), 32'd0);
    checkOutput({tag, "_im_addr"}, 32'(bus.im_addr), 32'd0);
    checkOutput({tag, "_im_wdata"}, bus.im_wdata, 32'h0);
    checkOutput({tag, "_word_count"}, 32'(bus.word_count), 32'd0);
    checkOutput({tag, "_err"}, 32'(bus.err), 32'd0);
    checkOutput({tag, "_full"}, 32'(bus.full), 32'd0);
  endtask

  // Monitor: every write and every rejection is matched against the
  // scoreboard; anything not expected is a failure.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.im_we === 1'b1) begin
        if (wrQ.size() == 0) begin
          tests++;
          errors++;
          $display("[TB] FAIL unexpected_write: addr %0d data 0x%08h, no write expected",
                   bus.im_addr, bus.im_wdata);
        end else begin
          monE = wrQ.pop_front();
          checkOutput({monE.name, "_addr"}, 32'(bus.im_addr), 32'(monE.addr));
          checkOutput({monE.name, "_data"}, bus.im_wdata, monE.data);
        end
      end
      if (bus.err === 1'b1) begin
        tests++;
        if (errPending == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_err: err=1, expected 0");
        end else begin
          errPending--;
        end
      end
    end
  end

  initial begin
    logic [31:0] expCnt;
    rst          = 1'b1;
    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    bus.fmt      = 3'b000;
    bus.opcode   = 7'h00;
    bus.funct3   = 3'b000;
    bus.funct7   = 7'h00;
    bus.rd       = 5'd0;
    bus.rs1      = 5'd0;
    bus.rs2      = 5'd0;
    bus.imm      = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkResetValues("reset");

    // First fill: addi, add, sw, an illegal format, then beq fills memory.
    applyStimulus(3'b000, 7'b0010011, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5,
                  K_WR, 32'h00500093, "addi");
    settle();
    checkIdleState("after_addi", 32'd1, 32'd1);
    applyStimulus(3'b101, 7'b0110011, 3'b000, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0,
                  K_WR, 32'h002081B3, "add");
    applyStimulus(3'b001, 7'b0100011, 3'b010, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8,
                  K_WR, 32'h0020A423, "sw");
    settle();
    applyStimulus(3'b110, 7'b0110011, 3'b000, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0,
                  K_ERR, 32'h0, "fmt110");
    settle();
    checkIdleState("after_fmt110", 32'd3, 32'd3);
    applyStimulus(3'b010, 7'b1100011, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC,
                  K_WR, 32'hFE000EE3, "beq_m4");
    settle();
    checkOutput("full_flag", 32'(bus.full), 32'd1);
    checkOutput("full_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("full_word_count", 32'(bus.word_count), 32'd4);

    // A bundle offered while full must be ignored.
    @(negedge clk);
    bus.fmt      = 3'b000;
    bus.opcode   = 7'b0010011;
    bus.rd       = 5'd1;
    bus.imm      = 32'd7;
    bus.in_valid = 1'b1;
    repeat (5) @(negedge clk);
    bus.in_valid = 1'b0;
    settle();
    checkOutput("full_hold_count", 32'(bus.word_count), 32'd4);
    checkOutput("full_hold_flag", 32'(bus.full), 32'd1);

    doClear();
    checkIdleState("after_clear1", 32'd0, 32'd0);

    // Second fill: lui and the immediate shifts (funct7 path) and jal.
    applyStimulus(3'b100, 7'b0110111, 3'b000, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345000,
                  K_WR, 32'h123452B7, "lui");
    applyStimulus(3'b000, 7'b0010011, 3'b001, 7'h00, 5'd1, 5'd2, 5'd0, 32'd3,
                  K_WR, 32'h00311093, "slli");
    applyStimulus(3'b000, 7'b0010011, 3'b101, 7'h20, 5'd1, 5'd2, 5'd0, 32'd3,
                  K_WR, 32'h40315093, "srai");
    applyStimulus(3'b011, 7'b1101111, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd8,
                  K_WR, 32'h008000EF, "jal_p8");
    settle();
    checkOutput("fill2_full", 32'(bus.full), 32'd1);
    doClear();
    checkIdleState("after_clear2", 32'd0, 32'd0);

    // Third group: negative offsets, then out-of-range immediates whose
    // outcome depends on whether range checking is built in.
    applyStimulus(3'b011, 7'b1101111, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFFFFF8,
                  K_WR, 32'hFF9FF06F, "jal_m8");
    applyStimulus(3'b001, 7'b0100011, 3'b010, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC,
                  K_WR, 32'hFE20AE23, "sw_m4");
    applyStimulus(3'b010, 7'b1100011, 3'b000, 7'h00, 5'd0, 5'd1, 5'd2, 32'd3,
                  RANGE_CHK ? K_ERR : K_WR, 32'h00208163, "beq_odd");
    settle();
    expCnt = RANGE_CHK ? 32'd2 : 32'd3;
    checkOutput("beq_odd_count", 32'(bus.word_count), expCnt);
    checkOutput("beq_odd_addr", 32'(bus.im_addr), expCnt);
    applyStimulus(3'b000, 7'b0010011, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd4096,
                  RANGE_CHK ? K_ERR : K_WR, 32'h00000093, "addi_4096");
    settle();
    expCnt = RANGE_CHK ? 32'd2 : 32'd4;
    checkOutput("addi_4096_count", 32'(bus.word_count), expCnt);
    checkOutput("addi_4096_full", 32'(bus.full), RANGE_CHK ? 32'd0 : 32'd1);
    doClear();

    // clear together with in_valid in IDLE: nothing is captured.
    @(negedge clk);
    bus.fmt      = 3'b000;
    bus.opcode   = 7'b0010011;
    bus.imm      = 32'd1;
    bus.in_valid = 1'b1;
    bus.clear    = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.clear    = 1'b0;
    checkOutput("clear_wins_ready", 32'(bus.in_ready), 32'd1);
    settle();
    checkIdleState("clear_wins", 32'd0, 32'd0);

    // rst while a bundle is being encoded.
    applyStimulus(3'b000, 7'b0010011, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5,
                  K_WR, 32'h00500093, "pre_rst_addi");
    settle();
    applyStimulus(3'b101, 7'b0110011, 3'b000, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0,
                  K_NONE, 32'h0, "rst_victim");
    rst = 1'b1;
    #1;
    checkResetValues("rst_in_enc");
    @(negedge clk);
    rst = 1'b0;
    modelPtr = '0;
    applyStimulus(3'b101, 7'b0110011, 3'b000, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0,
                  K_WR, 32'h002081B3, "post_rst_add");
    settle();
    checkIdleState("post_rst", 32'd1, 32'd1);

    // clear while a write is pending.
    applyStimulus(3'b100, 7'b0110111, 3'b000, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345000,
                  K_NONE, 32'h0, "clear_victim");
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    modelPtr = '0;
    checkResetValues("clear_in_enc");
    settle();
    applyStimulus(3'b011, 7'b1101111, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd8,
                  K_WR, 32'h008000EF, "post_clear_jal");
    settle();
    checkIdleState("post_clear", 32'd1, 32'd1);

    checkOutput("writes_outstanding", 32'(wrQ.size()), 32'd0);
    checkOutput("errs_outstanding", 32'(errPending), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
